// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the fetch-stage PC unit.
package pc_pkg;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0040_0000;
    localparam int          PC_INC          = 4;

    // Listed in priority order, highest first.
    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_FLUSH,
        SRC_HOLD,
        SRC_RAS,
        SRC_BRANCH,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Register-based return-address stack: circular pointer, saturating count,
// and a combined push+pop that replaces the top entry in place.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;
    logic             empty;
    logic             full;

    // ptr names the next free slot; the top of stack sits just below it.
    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = ptr;
        if (!reset && push) begin
            wr_en = 1'b1;
            if (pop && !empty)
                wr_idx = top_idx;
        end
    end

    // NOTE: the entry array carries no reset; count==0 already marks its contents as invalid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop) begin
            // Swap on an empty stack degenerates into a plain push.
            if (empty) begin
                ptr   <= ptr + PTR_W'(1);
                count <= CNT_W'(1);
            end
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: prioritised next-PC select, PC register,
// return-address stack and registered RAS underflow flag.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(PC_RESET_VECTOR),
    parameter int           INC          = PC_INC,
    parameter int           RAS_DEPTH    = 4,
    localparam int          CNT_W        = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush_valid,
    input  logic [N-1:0]     flush_target,
    input  logic             branch_valid,
    input  logic [N-1:0]     branch_target,
    input  logic             call,
    input  logic             ret,
    output logic [N-1:0]     PC_Value,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_underflow
);

    pc_src_e      src;
    logic [N-1:0] pc_next;
    logic [N-1:0] pc_inc;
    logic [N-1:0] ras_top;
    logic [N-1:0] flush_aligned;
    logic [N-1:0] branch_aligned;
    logic         jump_accepted;
    logic         ras_push;
    logic         ras_pop;
    logic         ras_empty;
    logic         underflow_next;

    assign pc_inc         = PC_Value + N'(INC);
    assign flush_aligned  = flush_target & ~N'(1);
    assign branch_aligned = branch_target & ~N'(1);
    assign ras_empty      = (ras_count == '0);

    // call/ret only act on a taken jump that is not overridden by reset, flush or stall.
    assign jump_accepted  = branch_valid && !reset && !flush_valid && !stall;
    assign ras_push       = jump_accepted && call;
    assign ras_pop        = jump_accepted && ret;
    assign underflow_next = ras_pop && ras_empty;

    always_comb begin
        src = SRC_SEQ;
        if (reset)
            src = SRC_RESET;
        else if (flush_valid)
            src = SRC_FLUSH;
        else if (stall)
            src = SRC_HOLD;
        else if (branch_valid && ret && !ras_empty)
            src = SRC_RAS;
        else if (branch_valid)
            src = SRC_BRANCH;
    end

    always_comb begin
        pc_next = pc_inc;
        case (src)
            SRC_RESET:  pc_next = RESET_VECTOR;
            SRC_FLUSH:  pc_next = flush_aligned;
            SRC_HOLD:   pc_next = PC_Value;
            SRC_RAS:    pc_next = ras_top;
            SRC_BRANCH: pc_next = branch_aligned;
            SRC_SEQ:    pc_next = pc_inc;
            default:    pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC_Value      <= RESET_VECTOR;
            ras_underflow <= 1'b0;
        end else begin
            PC_Value      <= pc_next;
            ras_underflow <= underflow_next;
        end
    end

    ras_stack #(
        .WIDTH (N),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: stimulus queues hand-computed
// expectations, a monitor pops and compares them after each rising edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush_valid;
    logic [31:0] flush_target;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        call;
    logic        ret;
    logic [31:0] PC_Value;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        uf;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush_valid   (flush_valid),
        .flush_target  (flush_target),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .call          (call),
        .ret           (ret),
        .PC_Value      (PC_Value),
        .ras_count     (ras_count),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // One cycle of stimulus plus the state expected right after the next rising edge.
    task automatic step(input logic rst, input logic st,
                        input logic fv, input logic [31:0] ft,
                        input logic bv, input logic [31:0] bt,
                        input logic c, input logic r,
                        input logic [31:0] epc, input logic [2:0] ecnt,
                        input logic euf, input string nm);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        stall         = st;
        flush_valid   = fv;
        flush_target  = ft;
        branch_valid  = bv;
        branch_target = bt;
        call          = c;
        ret           = r;
        e.pc   = epc;
        e.cnt  = ecnt;
        e.uf   = euf;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] epc, input logic [2:0] ecnt, input logic euf, input string nm);
        step(0, 0, 0, 0, 0, 0, 0, 0, epc, ecnt, euf, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".pc"},  PC_Value,               e.pc);
                check({e.name, ".cnt"}, {29'd0, ras_count},     {29'd0, e.cnt});
                check({e.name, ".uf"},  {31'd0, ras_underflow}, {31'd0, e.uf});
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; stall = 1'b0; flush_valid = 1'b0; flush_target = '0;
        branch_valid = 1'b0; branch_target = '0; call = 1'b0; ret = 1'b0;

        //   rst st fv ft            bv bt            c  r  exp_pc        cnt uf
        step(1, 0, 0, 0,            0, 0,            0, 0, 32'h0040_0000, 0, 0, "reset0");
        step(1, 0, 0, 0,            0, 0,            0, 0, 32'h0040_0000, 0, 0, "reset1");
        idle(32'h0040_0004, 0, 0, "inc1");
        idle(32'h0040_0008, 0, 0, "inc2");
        step(0, 1, 0, 0,            0, 0,            0, 0, 32'h0040_0008, 0, 0, "stall1");
        step(0, 1, 0, 0,            0, 0,            0, 0, 32'h0040_0008, 0, 0, "stall2");
        step(0, 1, 0, 0,            0, 0,            0, 0, 32'h0040_0008, 0, 0, "stall3");
        step(0, 1, 1, 32'h0040_1001, 0, 0,           0, 0, 32'h0040_1000, 0, 0, "flush_over_stall");
        step(0, 1, 0, 0,            1, 32'h0000_0040, 0, 1, 32'h0040_1000, 0, 0, "stall_ret_empty");
        step(0, 0, 1, 32'h0040_0011, 0, 0,           0, 0, 32'h0040_0010, 0, 0, "flush_align");

        step(0, 0, 0, 0,            1, 32'h0040_0100, 1, 0, 32'h0040_0100, 1, 0, "call");
        idle(32'h0040_0104, 1, 0, "after_call");
        step(0, 0, 0, 0,            1, 32'h0000_0000, 0, 1, 32'h0040_0014, 0, 0, "ret");
        step(0, 1, 0, 0,            1, 32'h0000_0123, 1, 0, 32'h0040_0014, 0, 0, "stall_call");
        step(0, 0, 0, 0,            0, 32'h0000_0123, 1, 0, 32'h0040_0018, 0, 0, "call_no_bv");
        step(0, 0, 0, 0,            0, 32'h0000_0123, 0, 1, 32'h0040_001C, 0, 0, "ret_no_bv");

        // RAS_DEPTH+1 nested calls; the fifth overwrites the oldest entry.
        step(0, 0, 0, 0,            1, 32'h0040_1000, 1, 0, 32'h0040_1000, 1, 0, "ovf_call1");
        step(0, 0, 0, 0,            1, 32'h0040_2000, 1, 0, 32'h0040_2000, 2, 0, "ovf_call2");
        step(0, 0, 0, 0,            1, 32'h0040_3000, 1, 0, 32'h0040_3000, 3, 0, "ovf_call3");
        step(0, 0, 0, 0,            1, 32'h0040_4000, 1, 0, 32'h0040_4000, 4, 0, "ovf_call4");
        step(0, 0, 0, 0,            1, 32'h0040_5001, 1, 0, 32'h0040_5000, 4, 0, "ovf_call5");
        step(0, 0, 0, 0,            1, 32'h0000_0100, 0, 1, 32'h0040_4004, 3, 0, "ovf_ret1");
        step(0, 0, 0, 0,            1, 32'h0000_0100, 0, 1, 32'h0040_3004, 2, 0, "ovf_ret2");
        step(0, 0, 0, 0,            1, 32'h0000_0100, 0, 1, 32'h0040_2004, 1, 0, "ovf_ret3");
        step(0, 0, 0, 0,            1, 32'h0000_0100, 0, 1, 32'h0040_1004, 0, 0, "ovf_ret4");
        step(0, 0, 0, 0,            1, 32'h0050_0003, 0, 1, 32'h0050_0002, 0, 1, "underflow");
        idle(32'h0050_0006, 0, 0, "underflow_clear");

        step(0, 0, 0, 0,            1, 32'h0060_0000, 1, 0, 32'h0060_0000, 1, 0, "push_then");
        step(0, 0, 0, 0,            1, 32'h0000_0000, 0, 1, 32'h0050_000A, 0, 0, "pop_next");

        // Coroutine swap with one entry, then with an empty stack.
        step(0, 0, 1, 32'h0040_004C, 0, 0,           0, 0, 32'h0040_004C, 0, 0, "co_setup");
        step(0, 0, 0, 0,            1, 32'h0040_001C, 1, 0, 32'h0040_001C, 1, 0, "co_push");
        idle(32'h0040_0020, 1, 0, "co_pc");
        step(0, 0, 0, 0,            1, 32'h0000_0000, 1, 1, 32'h0040_0050, 1, 0, "co_swap");
        step(0, 0, 0, 0,            1, 32'h0000_0000, 0, 1, 32'h0040_0024, 0, 0, "co_new_top");
        step(0, 0, 0, 0,            1, 32'h0070_0001, 1, 1, 32'h0070_0000, 1, 1, "co_swap_empty");
        step(0, 0, 0, 0,            1, 32'h0000_0000, 0, 1, 32'h0040_0028, 0, 0, "co_empty_top");

        step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0010, 1, 0, 32'hFFFF_FFFC, 0, 0, "flush_call");
        idle(32'h0000_0000, 0, 0, "wrap");

        // Reset while a call is being presented with three entries live.
        step(0, 0, 0, 0,            1, 32'h0000_0100, 1, 0, 32'h0000_0100, 1, 0, "pre_rst1");
        step(0, 0, 0, 0,            1, 32'h0000_0200, 1, 0, 32'h0000_0200, 2, 0, "pre_rst2");
        step(0, 0, 0, 0,            1, 32'h0000_0300, 1, 0, 32'h0000_0300, 3, 0, "pre_rst3");
        step(1, 0, 0, 0,            1, 32'h0000_0900, 1, 0, 32'h0040_0000, 0, 0, "reset_mid_call");
        step(0, 0, 0, 0,            1, 32'h0000_1235, 0, 1, 32'h0000_1234, 0, 1, "post_rst_ret");
        idle(32'h0000_1238, 0, 0, "post_rst_inc");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the RISC-V pipeline. It holds the fetch PC and computes the next PC each cycle from these sources, in priority order:
- reset vector
- trap/flush redirect
- pipeline stall (hold)
- return-address-stack (RAS) prediction
- branch/jump target
- sequential increment

The RAS stores return addresses for call/return pairs. The block sits at the front of the IF stage and feeds instruction memory and the IF/ID register.

## Interface
Parameters:
- N, 32, PC and address width
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, number of RAS entries (≥2, power of two)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard bubble; holds PC and RAS
- flush_valid  in  1  trap/exception redirect request
- flush_target  in  N  redirect address
- branch_valid  in  1  taken branch/jump this cycle
- branch_target  in  N  resolved branch/jump address
- call  in  1  jump is a call (jal/jalr with rd=ra); qualified by branch_valid
- ret  in  1  jump is a return (jalr x0, ra); qualified by branch_valid
- PC_Value  out  N  current fetch PC (registered)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_underflow  out  1  registered one-cycle pulse: ret accepted with RAS empty

## Operation
Next-state selection is evaluated every cycle; first match wins:
1. reset: PC_Value=RESET_VECTOR, ras_count=0, RAS pointer=0, ras_underflow=0. RAS contents are don't-care.
2. flush_valid: PC_Value={flush_target[N-1:1],1'b0}. RAS unchanged. call/ret ignored. Flush overrides stall.
3. stall: PC_Value, RAS and ras_count all hold. call/ret/branch ignored. ras_underflow=0.
4. branch_valid with ret=1:
   - If ras_count>0: PC ← RAS top; pop.
   - If ras_count=0: PC ← branch_target with bit 0 cleared; ras_underflow=1 next cycle.
5. branch_valid with call=1 and ret=0: PC ← branch_target with bit 0 cleared; push PC_Value+INC.
6. branch_valid alone: PC ← branch_target with bit 0 cleared.
7. Otherwise: PC ← PC_Value+INC, modulo 2^N (wraps at all-ones).

call and ret both set (coroutine swap):
- Target is the old RAS top. If empty, branch_target with bit 0 cleared, plus underflow.
- The top entry is replaced by PC_Value+INC. ras_count is unchanged; if it was 0 it becomes 1.

Push when full:
- Circular overwrite of the oldest entry.
- Pointer wraps modulo RAS_DEPTH; ras_count saturates at RAS_DEPTH.

Pop when empty: pointer and ras_count unchanged.

call or ret without branch_valid: ignored.

## Timing
- Single clock domain. All outputs are registered; no combinational input-to-output path.
- Redirect latency is 1 cycle: inputs sampled at edge k appear on PC_Value after edge k.
- reset asserted mid-stall or mid-branch wins at the same edge.
- After reset deasserts, the first increment occurs at the next edge with no stall.
- ras_underflow is high for exactly the cycle after the offending edge. It cannot assert during stall, flush or reset.
- A push followed by a pop on the next cycle returns the just-pushed value (no forwarding hazard; RAS is register-based).

## Structure
- Shared package pc_pkg holds:
  - PC_RESET_VECTOR and PC_INC constants
  - the next-PC source select enum: SRC_RESET, SRC_FLUSH, SRC_HOLD, SRC_RAS, SRC_BRANCH, SRC_SEQ
- One sub-module, ras_stack:
  - parameters: width, depth
  - ports: push, pop, push_data, top, count
  - behaviour: circular pointer, saturating count
- pc_sequencer contains the priority select logic, the PC register and the underflow flag.

## Test plan
- Reset and increment: reset=1 for 2 cycles, then release → PC_Value is 0x0040_0000, then 0x0040_0004, then 0x0040_0008. ras_count=0.
- Stall hold and flush priority: stall=1 for 3 cycles → PC is constant. With stall=1 and flush_valid=1, flush_target=0x0040_1001 → PC=0x0040_1000 next cycle.
- Call/return: at PC=0x0040_0010, branch_valid+call with target 0x0040_0100 → PC=0x0040_0100, ras_count=1. Later branch_valid+ret with branch_target=0x0 → PC=0x0040_0014, ras_count=0.
- Overflow: RAS_DEPTH+1 nested calls, then RAS_DEPTH+1 returns:
  - The first RAS_DEPTH returns pop in LIFO order; ras_count stays saturated at RAS_DEPTH during the pushes.
  - The final return uses branch_target, and ras_underflow pulses for 1 cycle.
- Coroutine and wrap:
  - With 1 entry (0x0040_0050) and PC=0x0040_0020, call+ret together → PC=0x0040_0050, top=0x0040_0024, ras_count=1.
  - With N=32, PC=0xFFFF_FFFC and no branch → PC=0x0000_0000.
- Reset mid-operation: reset asserted while branch_valid+call is active and ras_count=3 → PC=RESET_VECTOR, ras_count=0, no push recorded.
